// File: rtl/ifq_pkg.sv
// Shared types and helpers for the wide instruction fetch queue.
// PC helpers assume a power-of-two line size in instructions.
package ifq_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INST_BYTES = 4;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DISCARD
  } fetch_state_t;

  // Width of an in-line instruction offset; kept at least one bit wide.
  function automatic int unsigned off_bits(input int unsigned line_insts);
    return (line_insts > 1) ? $clog2(line_insts) : 1;
  endfunction

  // Width of a counter able to hold 0..n inclusive.
  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic logic [PC_W-1:0] line_base(input logic [PC_W-1:0] pc,
                                                input int unsigned     line_insts);
    return pc & ~(PC_W'(line_insts * INST_BYTES) - PC_W'(1));
  endfunction

  function automatic logic [PC_W-1:0] line_off(input logic [PC_W-1:0] pc,
                                               input int unsigned     line_insts);
    return (pc & (PC_W'(line_insts * INST_BYTES) - PC_W'(1))) >> 2;
  endfunction

  // Modular pointer add; valid while both operands are below depth.
  function automatic int unsigned ring_add(input int unsigned a,
                                           input int unsigned b,
                                           input int unsigned depth);
    int unsigned s;
    s = a + b;
    return (s >= depth) ? (s - depth) : s;
  endfunction

endpackage

// File: rtl/ifq_ring.sv
// Instruction-granular ring storage: one masked line write at wr_ptr and
// ISSUE_W combinational reads starting at rd_ptr, both modulo QDEPTH.
module ifq_ring
  import ifq_pkg::*;
#(
  parameter int unsigned INST_W     = 32,
  parameter int unsigned LINE_INSTS = 4,
  parameter int unsigned QDEPTH     = 16,
  parameter int unsigned ISSUE_W    = 2,
  parameter int unsigned PTR_W      = 4,
  parameter int unsigned OFF_W      = 2
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [PTR_W-1:0]             wr_ptr,
  input  logic [OFF_W-1:0]             wr_off,
  input  logic [INST_W*LINE_INSTS-1:0] wr_line,
  input  logic [PTR_W-1:0]             rd_ptr,
  output logic [INST_W*ISSUE_W-1:0]    rd_data
);

  logic [INST_W-1:0] mem [QDEPTH];

  // Slots below the entry offset are skipped; the rest pack from wr_ptr.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int unsigned j = 0; j < LINE_INSTS; j++) begin
        if (OFF_W'(j) >= wr_off) begin
          mem[PTR_W'(ring_add(32'(wr_ptr), j - 32'(wr_off), QDEPTH))] <=
            wr_line[j*INST_W +: INST_W];
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      rd_data[i*INST_W +: INST_W] = mem[PTR_W'(ring_add(32'(rd_ptr), i, QDEPTH))];
    end
  end

endmodule

// File: rtl/ifq_wide.sv
// Wide instruction fetch queue: prefetches cache lines into a ring and
// presents up to ISSUE_W sequential instructions per cycle, with redirect.
module ifq_wide
  import ifq_pkg::*;
#(
  parameter int unsigned    INST_W      = 32,
  parameter int unsigned    LINE_INSTS  = 4,
  parameter int unsigned    DEPTH_LINES = 4,
  parameter int unsigned    ISSUE_W     = 2,
  parameter logic [31:0]    RESET_PC    = 32'h0
) (
  input  logic                            clk,
  input  logic                            reset,
  output logic [31:0]                     Pc_in,
  output logic                            Rd_en_cache,
  input  logic [INST_W*LINE_INSTS-1:0]    Dout,
  input  logic                            Dout_valid,
  input  logic [31:0]                     Jmp_branch_address,
  input  logic                            Jmp_branch_valid,
  input  logic [$clog2(ISSUE_W+1)-1:0]    Rd_cnt,
  output logic [ISSUE_W*INST_W-1:0]       Inst,
  output logic [31:0]                     Pc_out,
  output logic [$clog2(ISSUE_W+1)-1:0]    Valid_cnt,
  output logic                            Empty
);

  localparam int unsigned QDEPTH = DEPTH_LINES * LINE_INSTS;
  localparam int unsigned PTR_W  = $clog2(QDEPTH);
  localparam int unsigned CNT_W  = cnt_bits(QDEPTH);
  localparam int unsigned RC_W   = $clog2(ISSUE_W + 1);
  localparam int unsigned OFF_W  = off_bits(LINE_INSTS);

  fetch_state_t      state, state_nx;
  logic [PC_W-1:0]   fetch_pc, fetch_pc_nx;
  logic [PC_W-1:0]   head_pc, head_pc_nx;
  logic [PC_W-1:0]   pc_req_nx;
  logic [PC_W-1:0]   redirect_pc;
  logic              req_nx;
  logic [PTR_W-1:0]  rd_ptr, rd_ptr_nx;
  logic [PTR_W-1:0]  wr_ptr, wr_ptr_nx;
  logic [CNT_W-1:0]  count, count_nx;
  logic [CNT_W-1:0]  rd_req, rd_eff, wr_num;
  logic [OFF_W-1:0]  off;
  logic              wr_en;
  logic [ISSUE_W*INST_W-1:0] rd_data;

  ifq_ring #(
    .INST_W     (INST_W),
    .LINE_INSTS (LINE_INSTS),
    .QDEPTH     (QDEPTH),
    .ISSUE_W    (ISSUE_W),
    .PTR_W      (PTR_W),
    .OFF_W      (OFF_W)
  ) u_ring (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_ptr  (wr_ptr),
    .wr_off  (off),
    .wr_line (Dout),
    .rd_ptr  (rd_ptr),
    .rd_data (rd_data)
  );

  // Never retire more than are held, nor more than were presented.
  always_comb begin
    rd_req = (Rd_cnt > RC_W'(ISSUE_W)) ? CNT_W'(ISSUE_W) : CNT_W'(Rd_cnt);
    rd_eff = (rd_req > count) ? count : rd_req;
  end

  assign off         = OFF_W'(line_off(fetch_pc, LINE_INSTS));
  assign wr_num      = CNT_W'(LINE_INSTS) - CNT_W'(off);
  assign redirect_pc = Jmp_branch_address & ~32'h3;

  // Fetch FSM, pointer and PC update; redirect overrides everything.
  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    head_pc_nx  = head_pc + (32'(rd_eff) * INST_BYTES);
    rd_ptr_nx   = PTR_W'(ring_add(32'(rd_ptr), 32'(rd_eff), QDEPTH));
    wr_ptr_nx   = wr_ptr;
    count_nx    = count - rd_eff;
    req_nx      = 1'b0;
    pc_req_nx   = Pc_in;
    wr_en       = 1'b0;

    unique case (state)
      IDLE: begin
        if ((CNT_W'(QDEPTH) - count) >= CNT_W'(LINE_INSTS)) begin
          req_nx    = 1'b1;
          pc_req_nx = line_base(fetch_pc, LINE_INSTS);
          state_nx  = WAIT;
        end
      end
      WAIT: begin
        if (Dout_valid) begin
          wr_en       = 1'b1;
          wr_ptr_nx   = PTR_W'(ring_add(32'(wr_ptr), 32'(wr_num), QDEPTH));
          count_nx    = count + wr_num - rd_eff;
          fetch_pc_nx = line_base(fetch_pc, LINE_INSTS) + 32'(LINE_INSTS * INST_BYTES);
          state_nx    = IDLE;
        end
      end
      DISCARD: begin
        if (Dout_valid) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase

    if (Jmp_branch_valid) begin
      count_nx    = '0;
      rd_ptr_nx   = '0;
      wr_ptr_nx   = '0;
      fetch_pc_nx = redirect_pc;
      head_pc_nx  = redirect_pc;
      req_nx      = 1'b0;
      pc_req_nx   = Pc_in;
      wr_en       = 1'b0;
      // A line still in flight must be swallowed before refetching.
      state_nx    = ((state == WAIT || state == DISCARD) && !Dout_valid) ? DISCARD : IDLE;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      Rd_en_cache <= 1'b0;
      Pc_in       <= '0;
    end else begin
      state       <= state_nx;
      fetch_pc    <= fetch_pc_nx;
      head_pc     <= head_pc_nx;
      rd_ptr      <= rd_ptr_nx;
      wr_ptr      <= wr_ptr_nx;
      count       <= count_nx;
      Rd_en_cache <= req_nx;
      Pc_in       <= pc_req_nx;
    end
  end

  // Head view: slots past the valid count read as zero.
  always_comb begin
    Valid_cnt = (count > CNT_W'(ISSUE_W)) ? RC_W'(ISSUE_W) : RC_W'(count);
    Inst      = '0;
    for (int unsigned i = 0; i < ISSUE_W; i++) begin
      if (RC_W'(i) < Valid_cnt) Inst[i*INST_W +: INST_W] = rd_data[i*INST_W +: INST_W];
    end
  end

  assign Pc_out = head_pc;
  assign Empty  = (count == '0);

endmodule
